// File: rtl/irq_axil_pkg.sv
// -----------------------------------------------------------------------------
// irq_axil_pkg
// Definitions shared by the IRQ-to-AXI-lite master and the irq_axil_sink slave.
//   - AXI-lite response codes.
//   - Default byte addresses of the M-mode and S-mode eip registers.
//   - Selector enum and decode helper for the two eip registers.
// No ports. This is a package.
// -----------------------------------------------------------------------------
package irq_axil_pkg;

  localparam logic [1:0] axil_resp_okay_gp   = 2'b00;
  localparam logic [1:0] axil_resp_slverr_gp = 2'b10;

  localparam logic [31:0] m_mode_plic_addr_gp = 32'h0030_b000;
  localparam logic [31:0] s_mode_plic_addr_gp = 32'h0030_b004;

  // Identifies which eip register an access targets. Addresses that match
  // neither register decode to EIP_SEL_NONE.
  typedef enum logic [1:0] {
    EIP_SEL_NONE = 2'd0,
    EIP_SEL_M    = 2'd1,
    EIP_SEL_S    = 2'd2
  } eip_sel_e;

  // The caller passes word addresses, which are byte addresses with the two
  // low bits dropped. The caller zero-extends each word address to 64 bits,
  // so one helper covers any address width the parameters allow.
  function automatic eip_sel_e eip_decode(input logic [63:0] word_addr,
                                          input logic [63:0] m_word,
                                          input logic [63:0] s_word);
    eip_decode = EIP_SEL_NONE;
    if (word_addr == m_word) begin
      eip_decode = EIP_SEL_M;
    end else if (word_addr == s_word) begin
      eip_decode = EIP_SEL_S;
    end
  endfunction

endpackage

// File: rtl/irq_axil_sink_wr.sv
// -----------------------------------------------------------------------------
// irq_axil_sink_wr
// This is the write side of irq_axil_sink. It holds the AW beat and the W beat
// independently. It commits the pair once the previous B has been accepted. It
// then drives the B channel. The eip registers are in the top level. This
// block only tells the top which register to update and with what value.
// Ports:
//   clk_i, reset_i         clock and synchronous active-high reset
//   s_axil_aw*             write-address channel (valid/ready/addr)
//   s_axil_w*              write-data channel (valid/ready/data/strb)
//   s_axil_b*              write-response channel
//   m_we_o / s_we_o        one-cycle update strobes for the M/S eip registers
//   we_data_o              new irq level that goes with the strobes
// -----------------------------------------------------------------------------
module irq_axil_sink_wr
  import irq_axil_pkg::*;
#(
  parameter int axil_data_width_p = 32,
  parameter int axil_addr_width_p = 32,
  parameter logic [axil_addr_width_p-1:0] m_mode_plic_addr_p = axil_addr_width_p'(m_mode_plic_addr_gp),
  parameter logic [axil_addr_width_p-1:0] s_mode_plic_addr_p = axil_addr_width_p'(s_mode_plic_addr_gp)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [axil_addr_width_p-1:0]   s_axil_awaddr_i,
  input  logic                           s_axil_awvalid_i,
  output logic                           s_axil_awready_o,
  input  logic [axil_data_width_p-1:0]   s_axil_wdata_i,
  input  logic [axil_data_width_p/8-1:0] s_axil_wstrb_i,
  input  logic                           s_axil_wvalid_i,
  output logic                           s_axil_wready_o,
  output logic [1:0]                     s_axil_bresp_o,
  output logic                           s_axil_bvalid_o,
  input  logic                           s_axil_bready_i,
  output logic                           m_we_o,
  output logic                           s_we_o,
  output logic                           we_data_o
);

  logic                         aw_held_q, aw_held_d;
  logic [axil_addr_width_p-3:0] awaddr_q, awaddr_d;
  logic                         w_held_q, w_held_d;
  logic                         wbit_q, wbit_d;
  logic                         wstrb0_q, wstrb0_d;
  logic                         bvalid_q, bvalid_d;
  logic [1:0]                   bresp_q, bresp_d;
  logic                         commit;
  eip_sel_e                     wr_sel;
  logic                         unused_wr;

  // Only bit 0 of the data and bit 0 of the strobe carry meaning. The low
  // address bits are ignored as well. All of them are folded away here.
  assign unused_wr = ^{s_axil_awaddr_i, s_axil_wdata_i, s_axil_wstrb_i};

  // The readies are forced low while reset is asserted. Then no beat looks
  // accepted during reset, and all slave outputs read as zero in reset.
  assign s_axil_awready_o = ~aw_held_q & ~reset_i;
  assign s_axil_wready_o  = ~w_held_q & ~reset_i;
  assign s_axil_bvalid_o  = bvalid_q;
  assign s_axil_bresp_o   = bresp_q;

  // A held pair may commit only when no B is outstanding. This keeps one B in
  // flight at a time, so a second captured write waits for bready.
  assign commit = aw_held_q & w_held_q & ~bvalid_q;
  assign wr_sel = eip_decode(64'(awaddr_q),
                             64'(m_mode_plic_addr_p[axil_addr_width_p-1:2]),
                             64'(s_mode_plic_addr_p[axil_addr_width_p-1:2]));

  // Register update strobes. A hit with strobe bit 0 clear still gets an OKAY
  // response, but it leaves the register untouched.
  assign m_we_o    = commit & (wr_sel == EIP_SEL_M) & wstrb0_q;
  assign s_we_o    = commit & (wr_sel == EIP_SEL_S) & wstrb0_q;
  assign we_data_o = wbit_q;

  // Next-state logic for the holding registers and the B channel. Capture and
  // commit never happen on the same edge, because capture needs a free slot
  // and commit needs both slots full.
  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wbit_d    = wbit_q;
    wstrb0_d  = wstrb0_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (s_axil_awvalid_i & s_axil_awready_o) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_axil_awaddr_i[axil_addr_width_p-1:2];
    end
    if (s_axil_wvalid_i & s_axil_wready_o) begin
      w_held_d = 1'b1;
      wbit_d   = s_axil_wdata_i[0];
      wstrb0_d = s_axil_wstrb_i[0];
    end
    if (bvalid_q & s_axil_bready_i) begin
      bvalid_d = 1'b0;
    end
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = (wr_sel == EIP_SEL_NONE) ? axil_resp_slverr_gp : axil_resp_okay_gp;
    end
  end

  // State register. Reset drops any held beats and any pending B response
  // with no trace.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wbit_q    <= 1'b0;
      wstrb0_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wbit_q    <= wbit_d;
      wstrb0_q  <= wstrb0_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

endmodule

// File: rtl/irq_axil_sink.sv
// -----------------------------------------------------------------------------
// irq_axil_sink
// This is an AXI-lite slave. It receives M-mode and S-mode external-interrupt
// levels from the PLIC-side master and drives them into the core as level
// interrupt lines. Software can also read both registers back.
// Ports:
//   clk_i, reset_i   clock and synchronous active-high reset
//   s_axil_aw*/w*/b* write channels. These are handled in irq_axil_sink_wr.
//   s_axil_ar*/r*    read channels: one outstanding read at a time
//   m_irq_o, s_irq_o registered M/S external interrupt levels
// -----------------------------------------------------------------------------
module irq_axil_sink
  import irq_axil_pkg::*;
#(
  parameter int axil_data_width_p = 32,
  parameter int axil_addr_width_p = 32,
  parameter logic [axil_addr_width_p-1:0] m_mode_plic_addr_p = axil_addr_width_p'(m_mode_plic_addr_gp),
  parameter logic [axil_addr_width_p-1:0] s_mode_plic_addr_p = axil_addr_width_p'(s_mode_plic_addr_gp)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [axil_addr_width_p-1:0]   s_axil_awaddr_i,
  input  logic [2:0]                     s_axil_awprot_i,
  input  logic                           s_axil_awvalid_i,
  output logic                           s_axil_awready_o,
  input  logic [axil_data_width_p-1:0]   s_axil_wdata_i,
  input  logic [axil_data_width_p/8-1:0] s_axil_wstrb_i,
  input  logic                           s_axil_wvalid_i,
  output logic                           s_axil_wready_o,
  output logic [1:0]                     s_axil_bresp_o,
  output logic                           s_axil_bvalid_o,
  input  logic                           s_axil_bready_i,
  input  logic [axil_addr_width_p-1:0]   s_axil_araddr_i,
  input  logic [2:0]                     s_axil_arprot_i,
  input  logic                           s_axil_arvalid_i,
  output logic                           s_axil_arready_o,
  output logic [axil_data_width_p-1:0]   s_axil_rdata_o,
  output logic [1:0]                     s_axil_rresp_o,
  output logic                           s_axil_rvalid_o,
  input  logic                           s_axil_rready_i,
  output logic                           m_irq_o,
  output logic                           s_irq_o
);

  logic                         m_irq_q, m_irq_d;
  logic                         s_irq_q, s_irq_d;
  logic                         rvalid_q, rvalid_d;
  logic [axil_data_width_p-1:0] rdata_q, rdata_d;
  logic [1:0]                   rresp_q, rresp_d;
  logic                         m_we, s_we, we_data;
  logic                         ar_fire;
  eip_sel_e                     rd_sel;
  logic                         unused_top;

  // The prot fields and the low read-address bits carry nothing for this
  // slave.
  assign unused_top = ^{s_axil_awprot_i, s_axil_arprot_i, s_axil_araddr_i};

  irq_axil_sink_wr #(
    .axil_data_width_p (axil_data_width_p),
    .axil_addr_width_p (axil_addr_width_p),
    .m_mode_plic_addr_p(m_mode_plic_addr_p),
    .s_mode_plic_addr_p(s_mode_plic_addr_p)
  ) wr_u (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .s_axil_awaddr_i (s_axil_awaddr_i),
    .s_axil_awvalid_i(s_axil_awvalid_i),
    .s_axil_awready_o(s_axil_awready_o),
    .s_axil_wdata_i  (s_axil_wdata_i),
    .s_axil_wstrb_i  (s_axil_wstrb_i),
    .s_axil_wvalid_i (s_axil_wvalid_i),
    .s_axil_wready_o (s_axil_wready_o),
    .s_axil_bresp_o  (s_axil_bresp_o),
    .s_axil_bvalid_o (s_axil_bvalid_o),
    .s_axil_bready_i (s_axil_bready_i),
    .m_we_o          (m_we),
    .s_we_o          (s_we),
    .we_data_o       (we_data)
  );

  // arready is also held low during reset, so every slave output is quiet
  // while reset is asserted.
  assign s_axil_arready_o = ~rvalid_q & ~reset_i;
  assign ar_fire          = s_axil_arvalid_i & s_axil_arready_o;
  assign rd_sel = eip_decode(64'(s_axil_araddr_i[axil_addr_width_p-1:2]),
                             64'(m_mode_plic_addr_p[axil_addr_width_p-1:2]),
                             64'(s_mode_plic_addr_p[axil_addr_width_p-1:2]));

  assign s_axil_rvalid_o = rvalid_q;
  assign s_axil_rdata_o  = rdata_q;
  assign s_axil_rresp_o  = rresp_q;
  assign m_irq_o         = m_irq_q;
  assign s_irq_o         = s_irq_q;

  // The eip registers change only on a commit strobe from the write side.
  // They feed the irq outputs directly, so no AXI input reaches the core
  // combinationally.
  always_comb begin
    m_irq_d = m_irq_q;
    s_irq_d = s_irq_q;
    if (m_we) begin
      m_irq_d = we_data;
    end
    if (s_we) begin
      s_irq_d = we_data;
    end
  end

  // Read channel. Read data is taken from the current register value at the
  // AR handshake edge. If a write commits on that same edge, the read returns
  // the old value. rdata and rresp hold until rready accepts them.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q & s_axil_rready_i) begin
      rvalid_d = 1'b0;
    end
    if (ar_fire) begin
      rvalid_d = 1'b1;
      case (rd_sel)
        EIP_SEL_M: begin
          rdata_d = axil_data_width_p'(m_irq_q);
          rresp_d = axil_resp_okay_gp;
        end
        EIP_SEL_S: begin
          rdata_d = axil_data_width_p'(s_irq_q);
          rresp_d = axil_resp_okay_gp;
        end
        default: begin
          rdata_d = '0;
          rresp_d = axil_resp_slverr_gp;
        end
      endcase
    end
  end

  // State register for the eip levels and the read response. A reset during
  // a read drops the pending R beat.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      m_irq_q  <= 1'b0;
      s_irq_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
    end else begin
      m_irq_q  <= m_irq_d;
      s_irq_q  <= s_irq_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

endmodule

// File: tb/tb_irq_axil_sink.sv
// -----------------------------------------------------------------------------
// tb_irq_axil_sink
// This bench runs directed sequences and then randomized single writes and
// reads. The model keeps the two irq levels as plain bits. It derives the
// expected response from the address rules and the strobe rule.
// -----------------------------------------------------------------------------
module tb_irq_axil_sink;

  localparam logic [31:0] MADDR    = 32'h0030_b000;
  localparam logic [31:0] SADDR    = 32'h0030_b004;
  localparam logic [31:0] MISSADDR = 32'h0030_b008;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        mIrqOut, sIrqOut;

  int   total = 0;
  int   bad = 0;
  logic mIrq = 1'b0;
  logic sIrq = 1'b0;

  irq_axil_sink dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .s_axil_awaddr_i (awaddr),
    .s_axil_awprot_i (awprot),
    .s_axil_awvalid_i(awvalid),
    .s_axil_awready_o(awready),
    .s_axil_wdata_i  (wdata),
    .s_axil_wstrb_i  (wstrb),
    .s_axil_wvalid_i (wvalid),
    .s_axil_wready_o (wready),
    .s_axil_bresp_o  (bresp),
    .s_axil_bvalid_o (bvalid),
    .s_axil_bready_i (bready),
    .s_axil_araddr_i (araddr),
    .s_axil_arprot_i (arprot),
    .s_axil_arvalid_i(arvalid),
    .s_axil_arready_o(arready),
    .s_axil_rdata_o  (rdata),
    .s_axil_rresp_o  (rresp),
    .s_axil_rvalid_o (rvalid),
    .s_axil_rready_i (rready),
    .m_irq_o         (mIrqOut),
    .s_irq_o         (sIrqOut)
  );

  // Free-running clock. Stimulus changes and sampling both happen on the
  // falling edge, away from the active edge.
  always #5 clk_i = ~clk_i;

  // Backstop so the run always ends, even if the design stalls completely.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Single comparison point. Every check is counted here, and every
  // mismatch is reported here.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Checks that every slave output is zero. Used while reset is asserted.
  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_awready"}, 32'(awready), 32'd0);
    checkOutput({tag, "_wready"},  32'(wready),  32'd0);
    checkOutput({tag, "_arready"}, 32'(arready), 32'd0);
    checkOutput({tag, "_bvalid"},  32'(bvalid),  32'd0);
    checkOutput({tag, "_bresp"},   32'(bresp),   32'd0);
    checkOutput({tag, "_rvalid"},  32'(rvalid),  32'd0);
    checkOutput({tag, "_rresp"},   32'(rresp),   32'd0);
    checkOutput({tag, "_rdata"},   rdata,        32'd0);
    checkOutput({tag, "_mirq"},    32'(mIrqOut), 32'd0);
    checkOutput({tag, "_sirq"},    32'(sIrqOut), 32'd0);
  endtask

  // Holds reset across one active edge, checks the quiet outputs, then
  // releases reset and clears the model.
  task automatic resetDut(input string tag);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    reset_i = 1'b1;
    @(negedge clk_i);
    checkAllZero(tag);
    reset_i = 1'b0;
    mIrq = 1'b0;
    sIrq = 1'b0;
    @(negedge clk_i);
  endtask

  // One complete write. AW and W are each delayed independently. The task
  // then checks commit latency, the response and the irq levels. Finally it
  // holds bready low for bDelay cycles before accepting B.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               input int awDelay, input int wDelay, input int bDelay);
    logic       awDone, wDone, awFire, wFire, expM, expS;
    logic [1:0] expResp;
    int         cyc;
    expM = mIrq;
    expS = sIrq;
    expResp = 2'b00;
    if ((addr >> 2) == (MADDR >> 2)) begin
      if (strb[0]) expM = data[0];
    end else if ((addr >> 2) == (SADDR >> 2)) begin
      if (strb[0]) expS = data[0];
    end else begin
      expResp = 2'b10;
    end
    awDone = 1'b0; wDone = 1'b0; cyc = 0;
    while (!(awDone && wDone) && cyc < 50) begin
      awvalid = !awDone && (cyc >= awDelay);
      awaddr  = addr;
      wvalid  = !wDone && (cyc >= wDelay);
      wdata   = data;
      wstrb   = strb;
      awFire  = awvalid && awready;
      wFire   = wvalid && wready;
      @(negedge clk_i);
      if (awFire) awDone = 1'b1;
      if (wFire)  wDone = 1'b1;
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    checkOutput("wr_handshakes", 32'({awDone, wDone}), 32'd3);
    checkOutput("wr_bvalid_early", 32'(bvalid), 32'd0);
    checkOutput("wr_mirq_before", 32'(mIrqOut), 32'(mIrq));
    checkOutput("wr_sirq_before", 32'(sIrqOut), 32'(sIrq));
    @(negedge clk_i);
    checkOutput("wr_bvalid", 32'(bvalid), 32'd1);
    checkOutput("wr_bresp", 32'(bresp), 32'(expResp));
    checkOutput("wr_mirq", 32'(mIrqOut), 32'(expM));
    checkOutput("wr_sirq", 32'(sIrqOut), 32'(expS));
    mIrq = expM;
    sIrq = expS;
    repeat (bDelay) begin
      @(negedge clk_i);
      checkOutput("wr_bvalid_hold", 32'(bvalid), 32'd1);
      checkOutput("wr_bresp_hold", 32'(bresp), 32'(expResp));
    end
    bready = 1'b1;
    @(negedge clk_i);
    bready = 1'b0;
    checkOutput("wr_single_b", 32'(bvalid), 32'd0);
  endtask

  // One complete read. rready is held low for rDelay cycles, and the task
  // checks that the response stays stable during that time.
  task automatic applyRead(input logic [31:0] addr, input int rDelay);
    logic [31:0] expData;
    logic [1:0]  expResp;
    if ((addr >> 2) == (MADDR >> 2)) begin
      expData = 32'(mIrq); expResp = 2'b00;
    end else if ((addr >> 2) == (SADDR >> 2)) begin
      expData = 32'(sIrq); expResp = 2'b00;
    end else begin
      expData = 32'd0; expResp = 2'b10;
    end
    checkOutput("rd_arready_idle", 32'(arready), 32'd1);
    araddr  = addr;
    arvalid = 1'b1;
    @(negedge clk_i);
    arvalid = 1'b0;
    checkOutput("rd_rvalid", 32'(rvalid), 32'd1);
    checkOutput("rd_rdata", rdata, expData);
    checkOutput("rd_rresp", 32'(rresp), 32'(expResp));
    checkOutput("rd_arready_busy", 32'(arready), 32'd0);
    repeat (rDelay) begin
      @(negedge clk_i);
      checkOutput("rd_rvalid_hold", 32'(rvalid), 32'd1);
      checkOutput("rd_rdata_hold", rdata, expData);
      checkOutput("rd_rresp_hold", 32'(rresp), 32'(expResp));
      checkOutput("rd_arready_hold", 32'(arready), 32'd0);
    end
    rready = 1'b1;
    @(negedge clk_i);
    rready = 1'b0;
    checkOutput("rd_rvalid_done", 32'(rvalid), 32'd0);
  endtask

  // A second write is captured while the first B is stalled. It must wait
  // for bready, and its B follows two cycles after the first B is accepted.
  task automatic backToBack();
    awaddr = MADDR; wdata = 32'd0; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk_i);
    awvalid = 1'b0; wvalid = 1'b0;
    checkOutput("b2b_first_early", 32'(bvalid), 32'd0);
    @(negedge clk_i);
    checkOutput("b2b_first_bvalid", 32'(bvalid), 32'd1);
    checkOutput("b2b_first_mirq", 32'(mIrqOut), 32'd0);
    mIrq = 1'b0;
    checkOutput("b2b_awready_free", 32'(awready), 32'd1);
    awaddr = SADDR; wdata = 32'd0; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk_i);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checkOutput("b2b_stall_bvalid", 32'(bvalid), 32'd1);
      checkOutput("b2b_stall_bresp", 32'(bresp), 32'd0);
      checkOutput("b2b_stall_sirq", 32'(sIrqOut), 32'(sIrq));
      checkOutput("b2b_stall_awready", 32'(awready), 32'd0);
      checkOutput("b2b_stall_wready", 32'(wready), 32'd0);
      @(negedge clk_i);
    end
    bready = 1'b1;
    @(negedge clk_i);
    checkOutput("b2b_first_done", 32'(bvalid), 32'd0);
    checkOutput("b2b_second_not_yet", 32'(sIrqOut), 32'(sIrq));
    @(negedge clk_i);
    checkOutput("b2b_second_bvalid", 32'(bvalid), 32'd1);
    checkOutput("b2b_second_bresp", 32'(bresp), 32'd0);
    checkOutput("b2b_second_sirq", 32'(sIrqOut), 32'd0);
    sIrq = 1'b0;
    @(negedge clk_i);
    bready = 1'b0;
    checkOutput("b2b_second_done", 32'(bvalid), 32'd0);
  endtask

  // Reset arrives while one B is pending and a new AW is held. After reset,
  // a lone W must not pair with the discarded AW.
  task automatic resetMidTransaction();
    awaddr = SADDR; wdata = 32'd1; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk_i);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk_i);
    checkOutput("rstmid_bvalid", 32'(bvalid), 32'd1);
    checkOutput("rstmid_sirq", 32'(sIrqOut), 32'd1);
    awaddr = MADDR; awvalid = 1'b1;
    @(negedge clk_i);
    awvalid = 1'b0;
    checkOutput("rstmid_aw_held", 32'(awready), 32'd0);
    resetDut("rstmid");
    checkOutput("rstmid_wready", 32'(wready), 32'd1);
    checkOutput("rstmid_awready", 32'(awready), 32'd1);
    wdata = 32'd1; wstrb = 4'h1; wvalid = 1'b1;
    @(negedge clk_i);
    wvalid = 1'b0;
    repeat (4) begin
      @(negedge clk_i);
      checkOutput("rstmid_no_b", 32'(bvalid), 32'd0);
      checkOutput("rstmid_mirq", 32'(mIrqOut), 32'd0);
    end
    resetDut("rstend");
  endtask

  initial begin
    logic [31:0] base, addr;
    int          pick;
    $display("[TB] start");
    @(negedge clk_i);
    @(negedge clk_i);
    checkAllZero("reset");
    reset_i = 1'b0;
    @(negedge clk_i);
    checkOutput("post_reset_awready", 32'(awready), 32'd1);
    checkOutput("post_reset_arready", 32'(arready), 32'd1);

    applyStimulus(SADDR, 32'd1, 4'h1, 0, 0, 0);
    applyStimulus(MADDR, 32'd1, 4'h1, 4, 0, 0);
    applyStimulus(MISSADDR, 32'd1, 4'h1, 0, 0, 0);
    applyRead(MISSADDR, 0);
    backToBack();
    applyStimulus(SADDR, 32'd1, 4'h1, 1, 2, 1);
    applyRead(SADDR, 3);
    applyStimulus(MADDR, 32'd1, 4'h1, 0, 0, 0);
    applyStimulus(MADDR, 32'd0, 4'he, 0, 0, 0);
    applyRead(MADDR | 32'd3, 0);

    for (int n = 0; n < 40; n++) begin
      pick = int'($urandom_range(0, 3));
      case (pick)
        0:       base = MADDR;
        1:       base = SADDR;
        2:       base = MISSADDR;
        default: base = $urandom;
      endcase
      addr = (base & 32'hffff_fffc) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin
        applyRead(addr, int'($urandom_range(0, 3)));
      end else begin
        applyStimulus(addr, $urandom, 4'($urandom_range(0, 15)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
    end

    resetMidTransaction();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_axil_sink.md
Name: irq_axil_sink

Overview:
- Downstream neighbour of the PLIC wrapper's IRQ-to-AXI-lite master.
- AXI-lite slave that receives single-beat writes carrying external-interrupt (eip) levels for M-mode and S-mode, holds them in registers, and drives level interrupt lines into the core.
- Supports read-back of both registers for software and debug.
- One outstanding write and one outstanding read at a time.

Parameters:
- axil_data_width_p, 32, AXI-lite data width; must be a multiple of 8 and at least 8.
- axil_addr_width_p, 32, AXI-lite address width.
- m_mode_plic_addr_p, 'h30_b000, byte address of the M-mode eip register.
- s_mode_plic_addr_p, 'h30_b004, byte address of the S-mode eip register.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- s_axil_awaddr_i  in  axil_addr_width_p  write address
- s_axil_awprot_i  in  3  ignored
- s_axil_awvalid_i / s_axil_awready_o  in/out  1  write-address handshake
- s_axil_wdata_i  in  axil_data_width_p  write data; bit 0 is the irq level
- s_axil_wstrb_i  in  axil_data_width_p/8  byte strobes; only bit 0 is significant
- s_axil_wvalid_i / s_axil_wready_o  in/out  1  write-data handshake
- s_axil_bresp_o  out  2  write response
- s_axil_bvalid_o / s_axil_bready_i  out/in  1  write-response handshake
- s_axil_araddr_i  in  axil_addr_width_p  read address
- s_axil_arprot_i  in  3  ignored
- s_axil_arvalid_i / s_axil_arready_o  in/out  1  read-address handshake
- s_axil_rdata_o  out  axil_data_width_p  read data
- s_axil_rresp_o  out  2  read response
- s_axil_rvalid_o / s_axil_rready_i  out/in  1  read-data handshake
- m_irq_o  out  1  M-mode external interrupt level
- s_irq_o  out  1  S-mode external interrupt level

Behaviour:
- Reset: all of the following are 0 — every ready, valid, resp and rdata output, m_irq_o, s_irq_o, and all held state.
- Reset asserted mid-transaction discards all held AW/W/AR and pending B/R; no response is ever issued for it.
- Address decode: compare addr[axil_addr_width_p-1:2] against the parameter addresses; addr[1:0] is ignored.
- Write path, capture:
  - awready_o = ~aw_held_r; wready_o = ~w_held_r.
  - AW and W are captured independently in any order or cycle; a handshake on either sets its held flag and stores addr, or data and strb.
- Write path, commit:
  - Occurs on the edge where aw_held_r & w_held_r & ~bvalid_o.
  - On an M-address hit with strb[0]=1: m_irq_r <= wdata[0]. S-address hit likewise updates s_irq_r.
  - A hit with strb[0]=0 leaves the register unchanged, bresp=OKAY (00).
  - A miss writes nothing, bresp=SLVERR (10).
  - The same edge clears both held flags and sets bvalid_o.
- Write path, response: bvalid_o holds with bresp stable until bready_i; it clears on the handshake edge.
- Write latency: AW and W in the same cycle N → held in N+1 → bvalid_o and new irq level visible in N+2.
- Back-to-back writes: the next AW/W may be captured while B is pending, but cannot commit until B completes. Peak throughput is one write per 2 cycles with bready tied high.
- Read path:
  - arready_o = ~rvalid_o.
  - On AR handshake at edge N: rvalid_o=1 in N+1.
  - rdata = {zeros, m_irq_r} or {zeros, s_irq_r} sampled at the handshake edge (the pre-commit value if a write commits on the same edge), rresp=OKAY.
  - A miss gives rdata=0, rresp=SLVERR.
  - rvalid_o and rdata hold until rready_i.
- Outputs: m_irq_o and s_irq_o are direct register outputs (no combinational path from AXI inputs).
- No protocol ordering between the read and write channels is required.

Decomposition:
- Shared package (irq_axil_pkg): axil_resp_okay_gp = 2'b00, axil_resp_slverr_gp = 2'b10, and the default M/S eip addresses, which the IRQ-to-AXI-lite master also imports.
- One natural sub-module: irq_axil_sink_wr, containing the AW/W holding registers, commit logic and B channel.
- The read path and eip registers stay in the top.

Test Plan:
- Reset, then AW='h30_b004 and W=1 (strb 1) in the same cycle, bready=1 → s_irq_o=1 two cycles later, bresp=00, m_irq_o stays 0.
- W (data 1, strb 1) in cycle 5, AW='h30_b000 in cycle 9 → m_irq_o=1 and bvalid in cycle 11, one B only.
- Write to 'h30_b008 data 1 → bresp=10, both irqs unchanged. Read of 'h30_b008 → rdata=0, rresp=10.
- bready held 0 for 10 cycles with a second AW/W presented → second write captured but not committed, B stable. Then bready=1 → second B follows two cycles later.
- Set s_irq via a write, then read 'h30_b004 with rready=0 for 3 cycles → rvalid, rdata=1 and rresp=00 held stable, arready=0 throughout.
- Assert reset while AW is held and B is pending → all outputs 0 the next cycle, no B after reset deasserts. Write with strb=0 → bresp=00, register unchanged.
